// File: rtl/switch_alloc_rr.sv
// NoC switch allocator: per-output round-robin arbitration with wormhole locking
// and a registered output stage that holds while the downstream link is full.
module switch_alloc_rr #(
  parameter int NPORTS   = 5,
  parameter int DATASIZE = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPORTS-1:0]            in_valid,
  input  logic [NPORTS*NPORTS-1:0]     in_req,
  input  logic [NPORTS*DATASIZE-1:0]   in_data,
  output logic [NPORTS-1:0]            in_ready,
  input  logic [NPORTS-1:0]            out_full,
  output logic [NPORTS-1:0]            out_valid,
  output logic [NPORTS*DATASIZE-1:0]   out_data,
  output logic [NPORTS*NPORTS-1:0]     out_grant,
  output logic [NPORTS-1:0]            out_locked
);
  localparam int PTRW = $clog2(NPORTS);
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  logic [NPORTS-1:0]          req_row  [NPORTS];
  logic [NPORTS-1:0]          req_col  [NPORTS];
  logic [NPORTS-1:0]          gnt      [NPORTS];
  logic [NPORTS-1:0]          gnt_any;
  logic [PTRW-1:0]            win_idx  [NPORTS];
  logic [DATASIZE-1:0]        win_flit [NPORTS];

  logic [NPORTS-1:0]          lock_q, lock_d;
  logic [PTRW-1:0]            owner_q  [NPORTS];
  logic [PTRW-1:0]            owner_d  [NPORTS];
  logic [PTRW-1:0]            ptr_q    [NPORTS];
  logic [PTRW-1:0]            ptr_d    [NPORTS];
  logic [NPORTS-1:0]          vld_q, vld_d;
  logic [NPORTS*DATASIZE-1:0] data_q, data_d;

  function automatic logic [NPORTS-1:0] lsb_only(input logic [NPORTS-1:0] x);
    return x & (~x + NPORTS'(1));
  endfunction

  // Descending scan so the requester closest to ptr (smallest offset) is kept last.
  function automatic logic [PTRW:0] rr_pick(input logic [NPORTS-1:0] req,
                                           input logic [PTRW-1:0]   ptr);
    int idx;
    rr_pick = '0;
    for (int k = NPORTS-1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NPORTS) idx -= NPORTS;
      if (req[idx]) rr_pick = {1'b1, PTRW'(idx)};
    end
  endfunction

  always_comb begin
    for (int i = 0; i < NPORTS; i++)
      req_row[i] = in_valid[i] ? lsb_only(in_req[i*NPORTS +: NPORTS]) : '0;
  end

  always_comb begin
    for (int j = 0; j < NPORTS; j++)
      for (int i = 0; i < NPORTS; i++)
        req_col[j][i] = req_row[i][j];
  end

  always_comb begin
    for (int j = 0; j < NPORTS; j++) begin
      gnt_any[j] = 1'b0;
      win_idx[j] = '0;
      gnt[j]     = '0;
      if (!out_full[j]) begin
        if (lock_q[j]) begin
          if (req_col[j][owner_q[j]]) begin
            gnt_any[j] = 1'b1;
            win_idx[j] = owner_q[j];
          end
        end else begin
          {gnt_any[j], win_idx[j]} = rr_pick(req_col[j], ptr_q[j]);
        end
      end
      gnt[j][win_idx[j]] = gnt_any[j];
    end
  end

  always_comb begin
    for (int j = 0; j < NPORTS; j++)
      win_flit[j] = in_data[int'(win_idx[j])*DATASIZE +: DATASIZE];
  end

  always_comb begin
    in_ready  = '0;
    out_grant = '0;
    for (int j = 0; j < NPORTS; j++) begin
      out_grant[j*NPORTS +: NPORTS] = gnt[j];
      in_ready = in_ready | gnt[j];
    end
  end

  // Lock/pointer bookkeeping and the output register next-state.
  always_comb begin
    lock_d = lock_q;
    vld_d  = vld_q;
    data_d = data_q;
    for (int j = 0; j < NPORTS; j++) begin
      owner_d[j] = owner_q[j];
      ptr_d[j]   = ptr_q[j];
      if (!out_full[j]) begin
        vld_d[j] = gnt_any[j];
        data_d[j*DATASIZE +: DATASIZE] = gnt_any[j] ? win_flit[j] : '0;
      end
      if (gnt_any[j]) begin
        if (win_flit[j][1:0] == FT_HEAD) begin
          lock_d[j]  = 1'b1;
          owner_d[j] = win_idx[j];
        end else if (win_flit[j][1:0] == FT_TAIL) begin
          lock_d[j] = 1'b0;
        end
        if (!lock_q[j] && (win_flit[j][1:0] == FT_HEAD || win_flit[j][1:0] == FT_SINGLE))
          ptr_d[j] = (int'(win_idx[j]) == NPORTS-1) ? '0 : win_idx[j] + PTRW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= '0;
      vld_q  <= '0;
      data_q <= '0;
      for (int j = 0; j < NPORTS; j++) begin
        owner_q[j] <= '0;
        ptr_q[j]   <= '0;
      end
    end else begin
      lock_q <= lock_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      for (int j = 0; j < NPORTS; j++) begin
        owner_q[j] <= owner_d[j];
        ptr_q[j]   <= ptr_d[j];
      end
    end
  end

  assign out_valid  = vld_q;
  assign out_data   = data_q;
  assign out_locked = lock_q;

endmodule

// File: tb/tb_switch_alloc_rr.sv
// Table-driven bench for switch_alloc_rr: hand-derived grant/lock expectations per
// cycle, registered outputs checked one cycle later through a scoreboard queue.
module tb_switch_alloc_rr;
  localparam int N  = 5;
  localparam int DW = 40;
  localparam int X  = -1;
  localparam logic [1:0] B = 2'b00, H = 2'b01, T = 2'b10, S = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    in_valid, in_ready, out_full, out_valid, out_locked;
  logic [N*N-1:0]  in_req, out_grant;
  logic [N*DW-1:0] in_data, out_data;

  switch_alloc_rr #(.NPORTS(N), .DATASIZE(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_req(in_req), .in_data(in_data),
    .in_ready(in_ready), .out_full(out_full), .out_valid(out_valid),
    .out_data(out_data), .out_grant(out_grant), .out_locked(out_locked)
  );

  typedef struct {
    int                 tag;
    logic               r;
    logic [N-1:0]       vld;
    logic [N*N-1:0]     req;
    logic [N-1:0][1:0]  typ;
    logic [N-1:0]       full;
    logic [N-1:0][2:0]  win;
    logic [N-1:0]       lk;
  } vec_t;

  typedef struct {
    logic [N-1:0]    vld;
    logic [N*DW-1:0] dat;
    logic [N-1:0]    lk;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  logic [N-1:0]    e_vld;
  logic [N*DW-1:0] e_dat;

  function automatic logic [DW-1:0] flit(int tag, int i, logic [1:0] ty);
    return {30'(tag), 8'(i), ty};
  endfunction

  function automatic logic [N*N-1:0] rq(int d0, int d1, int d2, int d3, int d4);
    int d[N];
    logic [N*N-1:0] r;
    d = '{d0, d1, d2, d3, d4};
    r = '0;
    for (int i = 0; i < N; i++) if (d[i] >= 0) r[i*N + d[i]] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0][1:0] t(logic [1:0] a, logic [1:0] b, logic [1:0] c,
                                          logic [1:0] d, logic [1:0] e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [N-1:0][2:0] w(int a, int b, int c, int d, int e);
    int v[N];
    logic [N-1:0][2:0] r;
    v = '{a, b, c, d, e};
    for (int j = 0; j < N; j++) r[j] = (v[j] < 0) ? 3'd7 : 3'(v[j]);
    return r;
  endfunction

  function automatic void add(int tag, logic r, logic [N-1:0] vld, logic [N*N-1:0] req,
                              logic [N-1:0][1:0] typ, logic [N-1:0] full,
                              logic [N-1:0][2:0] win, logic [N-1:0] lk);
    vec_t v;
    v.tag = tag; v.r = r; v.vld = vld; v.req = req; v.typ = typ;
    v.full = full; v.win = win; v.lk = lk;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [N*DW-1:0] act, logic [N*DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [N*N-1:0] eg;
    logic [N-1:0]   er;
    exp_t e;
    rst = v.r; in_valid = v.vld; in_req = v.req; out_full = v.full;
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = flit(v.tag, i, v.typ[i]);
    eg = '0;
    er = '0;
    for (int j = 0; j < N; j++)
      if (v.win[j] != 3'd7) begin
        eg[j*N + int'(v.win[j])] = 1'b1;
        er[v.win[j]] = 1'b1;
      end
    #2;
    chk($sformatf("v%0d out_grant", n), (N*DW)'(out_grant), (N*DW)'(eg));
    chk($sformatf("v%0d in_ready", n), (N*DW)'(in_ready), (N*DW)'(er));
    if (v.r) begin
      e_vld = '0;
      e_dat = '0;
    end else begin
      for (int j = 0; j < N; j++)
        if (!v.full[j]) begin
          e_vld[j] = (v.win[j] != 3'd7);
          e_dat[j*DW +: DW] = (v.win[j] != 3'd7) ?
                              flit(v.tag, int'(v.win[j]), v.typ[v.win[j]]) : '0;
        end
    end
    e.vld = e_vld; e.dat = e_dat; e.lk = v.lk;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d out_valid", n), (N*DW)'(out_valid), (N*DW)'(e.vld));
    chk($sformatf("v%0d out_data", n), out_data, e.dat);
    chk($sformatf("v%0d out_locked", n), (N*DW)'(out_locked), (N*DW)'(e.lk));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // first grant on output 1 from inputs {0,3}, then the loser
    add(1,  0, 5'b01001, rq(1,X,X,1,X), t(S,B,B,S,B), 5'b0, w(X,0,X,X,X), 5'b00000);
    add(2,  0, 5'b01000, rq(X,X,X,1,X), t(B,B,B,S,B), 5'b0, w(X,3,X,X,X), 5'b00000);
    // round-robin 0,2,4 on output 3
    for (int k = 0; k < 6; k++)
      add(3+k, 0, 5'b10101, rq(3,X,3,X,3), t(S,B,S,B,S), 5'b0,
          w(X,X,X,(k%3)*2,X), 5'b00000);
    // wormhole: input 1 packet on output 2, input 4 single waits
    add(9,  0, 5'b10010, rq(X,2,X,X,2), t(B,H,B,B,S), 5'b0, w(X,X,1,X,X), 5'b00100);
    add(10, 0, 5'b10010, rq(X,2,X,X,2), t(B,B,B,B,S), 5'b0, w(X,X,1,X,X), 5'b00100);
    add(11, 0, 5'b10010, rq(X,2,X,X,2), t(B,B,B,B,S), 5'b0, w(X,X,1,X,X), 5'b00100);
    add(12, 0, 5'b10010, rq(X,2,X,X,2), t(B,T,B,B,S), 5'b0, w(X,X,1,X,X), 5'b00000);
    add(13, 0, 5'b10000, rq(X,X,X,X,2), t(B,B,B,B,S), 5'b0, w(X,X,4,X,X), 5'b00000);
    // owner tail beats a competing head
    add(14, 0, 5'b00010, rq(X,2,X,X,X), t(B,H,B,B,B), 5'b0, w(X,X,1,X,X), 5'b00100);
    add(15, 0, 5'b01010, rq(X,2,X,2,X), t(B,T,B,H,B), 5'b0, w(X,X,1,X,X), 5'b00000);
    add(16, 0, 5'b01000, rq(X,X,X,2,X), t(B,B,B,H,B), 5'b0, w(X,X,3,X,X), 5'b00100);
    add(17, 0, 5'b01000, rq(X,X,X,2,X), t(B,B,B,T,B), 5'b0, w(X,X,3,X,X), 5'b00000);
    // backpressure on output 0, upstream holds the same flit
    add(18, 0, 5'b00100, rq(X,X,0,X,X), t(B,B,S,B,B), 5'b00000, w(2,X,X,X,X), 5'b0);
    for (int k = 0; k < 3; k++)
      add(19, 0, 5'b00100, rq(X,X,0,X,X), t(B,B,S,B,B), 5'b00001, w(X,X,X,X,X), 5'b0);
    add(19, 0, 5'b00100, rq(X,X,0,X,X), t(B,B,S,B,B), 5'b00000, w(2,X,X,X,X), 5'b0);
    add(23, 0, 5'b00100, rq(X,X,0,X,X), t(B,B,S,B,B), 5'b00000, w(2,X,X,X,X), 5'b0);
    // reset mid-packet
    add(24, 0, 5'b00010, rq(X,2,X,X,X), t(B,H,B,B,B), 5'b0, w(X,X,1,X,X), 5'b00100);
    add(25, 0, 5'b00010, rq(X,2,X,X,X), t(B,B,B,B,B), 5'b0, w(X,X,1,X,X), 5'b00100);
    add(26, 1, 5'b00000, rq(X,X,X,X,X), t(B,B,B,B,B), 5'b0, w(X,X,X,X,X), 5'b00000);
    add(27, 0, 5'b01000, rq(X,X,X,2,X), t(B,B,B,B,B), 5'b0, w(X,X,3,X,X), 5'b00000);
    // request corner cases: multi-bit request, empty request, invalid input
    add(28, 0, 5'b00001, 25'b00110, t(S,B,B,B,B), 5'b0, w(X,0,X,X,X), 5'b00000);
    add(29, 0, 5'b10100, 25'b0, t(S,S,S,S,S), 5'b0, w(X,X,X,X,X), 5'b00000);
    add(30, 0, 5'b00000, rq(1,X,X,X,X), t(S,B,B,B,B), 5'b0, w(X,X,X,X,X), 5'b00000);

    rst = 1'b1; in_valid = '0; in_req = '0; in_data = '0; out_full = '0;
    e_vld = '0; e_dat = '0;
    repeat (2) begin
      in_valid = N'($urandom);
      in_req   = (N*N)'($urandom);
      out_full = N'($urandom);
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'({$urandom, $urandom});
      @(posedge clk);
      #1;
    end
    chk("reset out_valid", (N*DW)'(out_valid), '0);
    chk("reset out_data", out_data, '0);
    chk("reset out_locked", (N*DW)'(out_locked), '0);

    for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k], k + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
